// File: rtl/vgm_cmd_seq.sv
// vgm_cmd_seq: VGM command sequencer issuing PSG/AY register writes and programming the sample-wait timer
module vgm_cmd_seq (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       tmr_wr,
  output logic       tmr_adr,
  output logic [7:0] tmr_data,
  input  logic       tmr_active,
  output logic       snd_wr,
  output logic       snd_sel,
  output logic [7:0] snd_adr,
  output logic [7:0] snd_data,
  output logic       busy,
  output logic       done,
  output logic       err
);
  typedef enum logic [3:0] {
    S_IDLE, S_OP, S_A1, S_A2, S_SND, S_TLO, S_THI, S_WSYNC, S_WAIT, S_DONE, S_ERR
  } state_t;
  state_t      r_state;
  logic [7:0]  r_op;
  logic [15:0] r_wait;
  logic        w_xfer;
  logic        w_fix_hit;
  logic [15:0] w_fix;
  assign in_ready  = r_state inside {S_OP, S_A1, S_A2};
  assign busy      = !(r_state inside {S_IDLE, S_DONE, S_ERR});
  assign w_xfer    = in_valid & in_ready;
  assign w_fix_hit = (in_data == 8'h62) || (in_data == 8'h63) || (in_data[7:4] == 4'h7);
  // wait length implied by a single-byte wait opcode
  always_comb begin
    w_fix = (in_data == 8'h62) ? 16'h02DF :
            (in_data == 8'h63) ? 16'h0372 : {12'h000, in_data[3:0]} + 16'd1;
  end
  // sequencer FSM; strobes are set on entry so they are high for the whole target state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_op     <= 8'h00;
      r_wait   <= 16'h0000;
      tmr_wr   <= 1'b0;
      tmr_adr  <= 1'b0;
      tmr_data <= 8'h00;
      snd_wr   <= 1'b0;
      snd_sel  <= 1'b0;
      snd_adr  <= 8'h00;
      snd_data <= 8'h00;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      snd_wr <= 1'b0;
      tmr_wr <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: if (start) begin
          r_state <= S_OP;
          done    <= 1'b0;
          err     <= 1'b0;
        end
        S_OP: if (w_xfer) begin
          r_op <= in_data;
          if (in_data == 8'h50 || in_data == 8'hA0 || in_data == 8'h61) r_state <= S_A1;
          else if (w_fix_hit) begin
            r_wait   <= w_fix;
            tmr_wr   <= 1'b1;
            tmr_adr  <= 1'b0;
            tmr_data <= w_fix[7:0];
            r_state  <= S_TLO;
          end else if (in_data == 8'h66) begin
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            err     <= 1'b1;
            r_state <= S_ERR;
          end
        end
        S_A1: if (w_xfer) begin
          if (r_op == 8'h50) begin
            snd_sel  <= 1'b0;
            snd_adr  <= 8'h00;
            snd_data <= in_data;
            snd_wr   <= 1'b1;
            r_state  <= S_SND;
          end else begin
            r_wait[7:0] <= in_data;
            r_state     <= S_A2;
          end
        end
        S_A2: if (w_xfer) begin
          if (r_op == 8'hA0) begin
            snd_sel  <= 1'b1;
            snd_adr  <= r_wait[7:0];
            snd_data <= in_data;
            snd_wr   <= 1'b1;
            r_state  <= S_SND;
          end else begin
            r_wait[15:8] <= in_data;
            tmr_wr       <= 1'b1;
            tmr_adr      <= 1'b0;
            tmr_data     <= r_wait[7:0];
            r_state      <= S_TLO;
          end
        end
        S_SND: r_state <= S_OP;
        S_TLO: begin
          tmr_wr   <= 1'b1;
          tmr_adr  <= 1'b1;
          tmr_data <= r_wait[15:8];
          r_state  <= S_THI;
        end
        S_THI:   r_state <= S_WSYNC;
        S_WSYNC: r_state <= S_WAIT;
        S_WAIT:  if (!tmr_active) r_state <= S_OP;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vgm_cmd_seq.sv
// tb_vgm_cmd_seq: directed bench for vgm_cmd_seq with a byte-stream source and a behavioural sample timer
module tb_vgm_cmd_seq;
  logic       clk, reset_n, start, in_valid, in_ready;
  logic [7:0] in_data;
  logic       tmr_wr, tmr_adr, tmr_active;
  logic [7:0] tmr_data;
  logic       snd_wr, snd_sel;
  logic [7:0] snd_adr, snd_data;
  logic       busy, done, err;
  logic [31:0] outs;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int tdiv = 2;
  int both_cnt = 0;
  bit gap = 0;
  logic [7:0]  q[$];
  logic [16:0] snd_log[$];
  int          snd_cyc[$];
  logic [8:0]  tmr_log[$];
  int          tmr_cyc[$];
  int          xfer_cyc[$];

  assign outs = {in_ready, tmr_wr, tmr_adr, tmr_data, snd_wr, snd_sel, snd_adr, snd_data, busy, done, err};

  vgm_cmd_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .tmr_wr(tmr_wr), .tmr_adr(tmr_adr), .tmr_data(tmr_data),
    .tmr_active(tmr_active), .snd_wr(snd_wr), .snd_sel(snd_sel), .snd_adr(snd_adr),
    .snd_data(snd_data), .busy(busy), .done(done), .err(err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // strobe monitor, sampled 1 time unit after each rising edge
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (snd_wr) begin
      snd_log.push_back({snd_sel, snd_adr, snd_data});
      snd_cyc.push_back(cyc);
    end
    if (tmr_wr) begin
      tmr_log.push_back({tmr_adr, tmr_data});
      tmr_cyc.push_back(cyc);
    end
    if (snd_wr && tmr_wr) both_cnt++;
  end

  // byte source: presents the queue head, optionally with random gaps, pops on a transfer
  initial begin
    bit pend;
    int pcyc;
    pend = 0;
    pcyc = 0;
    in_valid = 0;
    in_data = 0;
    forever begin
      @(negedge clk);
      if (pend) begin
        void'(q.pop_front());
        xfer_cyc.push_back(pcyc);
      end
      if (q.size() > 0 && (!gap || $urandom_range(0, 2) != 0)) begin
        in_valid = 1;
        in_data = q[0];
      end else begin
        in_valid = 0;
      end
      pend = in_valid && in_ready && reset_n;
      pcyc = cyc;
    end
  end

  // sample timer: low byte latched, high byte loads count; one sample every tdiv cycles
  initial begin
    logic [15:0] cnt;
    logic [7:0]  lo;
    int          pre;
    cnt = 0;
    lo = 0;
    pre = 0;
    tmr_active = 0;
    forever begin
      @(negedge clk);
      if (tmr_wr && !tmr_adr) lo = tmr_data;
      else if (tmr_wr && tmr_adr) begin
        cnt = {tmr_data, lo};
        pre = 0;
      end else if (cnt != 0) begin
        pre++;
        if (pre == tdiv) begin
          pre = 0;
          cnt--;
        end
      end
      tmr_active = (cnt != 0);
    end
  end

  function automatic logic [16:0] snd_at(int i);
    return (i < snd_log.size()) ? snd_log[i] : '1;
  endfunction
  function automatic logic [8:0] tmr_at(int i);
    return (i < tmr_log.size()) ? tmr_log[i] : '1;
  endfunction
  function automatic int scyc_at(int i);
    return (i < snd_cyc.size()) ? snd_cyc[i] : -100000;
  endfunction
  function automatic int tcyc_at(int i);
    return (i < tmr_cyc.size()) ? tmr_cyc[i] : -100000;
  endfunction
  function automatic int xcyc_at(int i);
    return (i < xfer_cyc.size()) ? xfer_cyc[i] : 100000;
  endfunction

  task automatic clear_logs;
    snd_log.delete();
    snd_cyc.delete();
    tmr_log.delete();
    tmr_cyc.delete();
    xfer_cyc.delete();
  endtask

  task automatic push3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input int n);
    q.push_back(a);
    if (n > 1) q.push_back(b);
    if (n > 2) q.push_back(c);
  endtask

  task automatic pulse_start;
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
  endtask

  task automatic drain(input int max);
    int n = 0;
    @(negedge clk);
    while (!(q.size() == 0 && !in_valid && in_ready) && n < max) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (n >= max) begin
      n_bad++;
      $display("FAIL drain_timeout got=%0d cycles queue=%0d busy=%b exp=stream consumed", n, q.size(), busy);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (outs !== 32'h0) begin n_bad++; $display("FAIL reset_outs got=%h exp=%h", outs, 32'h0); end
    reset_n = 1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (outs !== 32'h0) begin n_bad++; $display("FAIL idle_outs got=%h exp=%h", outs, 32'h0); end
    pulse_start;
    n_cmp++;
    if ({in_ready, busy} !== 2'b11) begin n_bad++; $display("FAIL start_op got=%b exp=%b", {in_ready, busy}, 2'b11); end
  endtask

  task automatic test_sn_write;
    clear_logs;
    push3(8'h50, 8'h9F, 8'h00, 2);
    push3(8'h50, 8'h8F, 8'h00, 2);
    drain(100);
    n_cmp++;
    if (snd_log.size() !== 2) begin n_bad++; $display("FAIL sn_count got=%0d exp=2", snd_log.size()); end
    n_cmp++;
    if ({snd_at(0), snd_at(1)} !== {17'h0009F, 17'h0008F}) begin
      n_bad++; $display("FAIL sn_data got=%h %h exp=0009f 0008f", snd_at(0), snd_at(1));
    end
    n_cmp++;
    if (scyc_at(0) - xcyc_at(0) !== 2) begin
      n_bad++; $display("FAIL sn_latency got=%0d exp=2", scyc_at(0) - xcyc_at(0));
    end
    n_cmp++;
    if (scyc_at(1) - scyc_at(0) !== 3) begin
      n_bad++; $display("FAIL back_to_back got=%0d exp=3", scyc_at(1) - scyc_at(0));
    end
  endtask

  task automatic test_ay_write;
    clear_logs;
    push3(8'hA0, 8'h07, 8'h38, 3);
    drain(100);
    n_cmp++;
    if (snd_log.size() !== 1 || snd_at(0) !== 17'h10738) begin
      n_bad++; $display("FAIL ay_write got=%h n=%0d exp=10738 n=1", snd_at(0), snd_log.size());
    end
    n_cmp++;
    if (tmr_log.size() !== 0) begin n_bad++; $display("FAIL ay_no_tmr got=%0d exp=0", tmr_log.size()); end
  endtask

  task automatic test_wait61;
    int d;
    tdiv = 82;
    clear_logs;
    push3(8'h61, 8'h10, 8'h00, 3);
    push3(8'h50, 8'h02, 8'h00, 2);
    drain(3000);
    n_cmp++;
    if (tmr_log.size() !== 2 || {tmr_at(0), tmr_at(1)} !== {9'h010, 9'h100}) begin
      n_bad++; $display("FAIL w61_tmr got=%h %h n=%0d exp=010 100", tmr_at(0), tmr_at(1), tmr_log.size());
    end
    n_cmp++;
    if (tcyc_at(1) - tcyc_at(0) !== 1) begin
      n_bad++; $display("FAIL w61_consec got=%0d exp=1", tcyc_at(1) - tcyc_at(0));
    end
    d = xcyc_at(3) - tcyc_at(1);
    n_cmp++;
    if (d < 1312 || d > 1320) begin n_bad++; $display("FAIL w61_stall got=%0d exp=1312..1320", d); end
    tdiv = 2;
  endtask

  task automatic test_fixed_waits;
    logic [7:0]  ops [3] = '{8'h62, 8'h63, 8'h75};
    logic [17:0] exp [3] = '{{9'h0DF, 9'h102}, {9'h072, 9'h103}, {9'h006, 9'h100}};
    for (int i = 0; i < 3; i++) begin
      clear_logs;
      q.push_back(ops[i]);
      drain(5000);
      n_cmp++;
      if (tmr_log.size() !== 2 || {tmr_at(0), tmr_at(1)} !== exp[i]) begin
        n_bad++; $display("FAIL fixed_wait_%h got=%h %h exp=%h", ops[i], tmr_at(0), tmr_at(1), exp[i]);
      end
    end
  endtask

  task automatic test_zero_wait;
    clear_logs;
    push3(8'h61, 8'h00, 8'h00, 3);
    push3(8'h50, 8'h01, 8'h00, 2);
    drain(100);
    n_cmp++;
    if ({tmr_at(0), tmr_at(1)} !== {9'h000, 9'h100}) begin
      n_bad++; $display("FAIL zero_tmr got=%h %h exp=000 100", tmr_at(0), tmr_at(1));
    end
    n_cmp++;
    if (xcyc_at(3) - tcyc_at(1) !== 3) begin
      n_bad++; $display("FAIL zero_refetch got=%0d exp=3", xcyc_at(3) - tcyc_at(1));
    end
  endtask

  task automatic test_start_busy;
    int n = 0;
    clear_logs;
    q.push_back(8'h7F);
    push3(8'h50, 8'h33, 8'h00, 2);
    while (!tmr_active && n < 50) begin @(negedge clk); n++; end
    pulse_start;
    n_cmp++;
    if ({busy, in_ready, done, err} !== 4'b1000) begin
      n_bad++; $display("FAIL start_busy got=%b exp=1000", {busy, in_ready, done, err});
    end
    drain(200);
    n_cmp++;
    if ({tmr_at(0), tmr_at(1)} !== {9'h010, 9'h100} || snd_log.size() !== 1 || snd_at(0) !== 17'h00033) begin
      n_bad++; $display("FAIL start_busy_seq got=%h %h %h exp=010 100 00033", tmr_at(0), tmr_at(1), snd_at(0));
    end
  endtask

  task automatic test_done;
    int n = 0;
    clear_logs;
    q.push_back(8'h66);
    while (!done && n < 20) begin @(negedge clk); n++; end
    n_cmp++;
    if ({done, busy, in_ready, err} !== 4'b1000) begin
      n_bad++; $display("FAIL done_state got=%b exp=1000", {done, busy, in_ready, err});
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (done !== 1'b1) begin n_bad++; $display("FAIL done_level got=%b exp=1", done); end
    pulse_start;
    n_cmp++;
    if ({done, busy, in_ready} !== 3'b011) begin
      n_bad++; $display("FAIL done_clear got=%b exp=011", {done, busy, in_ready});
    end
  endtask

  task automatic test_err;
    int n = 0;
    clear_logs;
    q.push_back(8'h42);
    while (!err && n < 20) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({err, busy, done, in_ready} !== 4'b1000) begin
      n_bad++; $display("FAIL err_state got=%b exp=1000", {err, busy, done, in_ready});
    end
    n_cmp++;
    if (snd_log.size() + tmr_log.size() !== 0) begin
      n_bad++; $display("FAIL err_strobes got=%0d exp=0", snd_log.size() + tmr_log.size());
    end
  endtask

  task automatic test_gapped;
    int n = 0;
    gap = 1;
    clear_logs;
    pulse_start;
    n_cmp++;
    if ({err, busy} !== 2'b01) begin n_bad++; $display("FAIL err_clear got=%b exp=01", {err, busy}); end
    push3(8'h50, 8'h9F, 8'hA0, 3);
    push3(8'h07, 8'h38, 8'h75, 3);
    q.push_back(8'h66);
    while (!done && n < 500) begin @(negedge clk); n++; end
    n_cmp++;
    if (snd_log.size() !== 2 || {snd_at(0), snd_at(1)} !== {17'h0009F, 17'h10738}) begin
      n_bad++; $display("FAIL gap_snd got=%h %h n=%0d exp=0009f 10738", snd_at(0), snd_at(1), snd_log.size());
    end
    n_cmp++;
    if (tmr_log.size() !== 2 || {tmr_at(0), tmr_at(1)} !== {9'h006, 9'h100} || done !== 1'b1) begin
      n_bad++; $display("FAIL gap_tmr got=%h %h done=%b exp=006 100 done=1", tmr_at(0), tmr_at(1), done);
    end
    gap = 0;
  endtask

  task automatic test_reset_wait;
    int n = 0;
    pulse_start;
    clear_logs;
    push3(8'h61, 8'h00, 8'h01, 3);
    while (!(tmr_active && !in_ready) && n < 50) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({busy, tmr_adr, tmr_active} !== 3'b111) begin
      n_bad++; $display("FAIL pre_reset got=%b exp=111", {busy, tmr_adr, tmr_active});
    end
    reset_n = 0;
    #1;
    n_cmp++;
    if (outs !== 32'h0) begin n_bad++; $display("FAIL async_reset got=%h exp=%h", outs, 32'h0); end
    @(negedge clk) reset_n = 1;
    @(negedge clk);
    n_cmp++;
    if ({busy, in_ready} !== 2'b00) begin n_bad++; $display("FAIL post_reset got=%b exp=00", {busy, in_ready}); end
    clear_logs;
    push3(8'h50, 8'h11, 8'h00, 2);
    pulse_start;
    drain(100);
    n_cmp++;
    if (snd_log.size() !== 1 || snd_at(0) !== 17'h00011 || tmr_log.size() !== 0) begin
      n_bad++; $display("FAIL resume got=%h n=%0d exp=00011 n=1", snd_at(0), snd_log.size());
    end
  endtask

  task automatic test_exclusive;
    n_cmp++;
    if (both_cnt !== 0) begin n_bad++; $display("FAIL strobe_overlap got=%0d exp=0", both_cnt); end
  endtask

  initial begin
    reset_n = 0;
    start = 0;
    test_reset;
    test_sn_write;
    test_ay_write;
    test_wait61;
    test_fixed_waits;
    test_zero_wait;
    test_start_busy;
    test_done;
    test_err;
    test_gapped;
    test_reset_wait;
    test_exclusive;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout got=cycle %0d exp=finish", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp + 1, n_bad + 1);
    $fatal(1);
  end
endmodule
